// File: rtl/timer_capture.sv
// Input-capture unit: synchronises an external event, latches a free-running
// count on the selected edge and reports the interval between captures.
module timer_capture #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_in,
    input  logic             capture_en,
    input  logic [1:0]       edge_sel,
    input  logic             interrupt_en,
    input  logic             ack,
    input  logic             clear_counter,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] captured,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             overrun,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WIDTH-1:0]       last;
    logic                   synced;
    logic                   rise;
    logic                   fall;
    logic                   edge_match;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;
    assign fall   = ~synced & prev_q;
    assign irq    = valid & interrupt_en;

    always_comb begin
        edge_match = 1'b0;
        case (edge_sel)
            2'b01:   edge_match = rise;
            2'b10:   edge_match = fall;
            2'b11:   edge_match = rise | fall;
            default: edge_match = 1'b0;
        endcase
    end

    assign accept = edge_match & capture_en & (state != IDLE);

    // The synchroniser runs even while disabled so enabling with the input
    // already high cannot manufacture a rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            counter <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], capture_in};
            prev_q <= synced;
            if (clear_counter) begin
                counter <= '0;
            end else if (capture_en) begin
                counter <= counter + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            captured <= '0;
            period   <= '0;
            last     <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // A new capture beats a simultaneous ack; the ack only consumes old data.
            if (accept) begin
                captured <= counter;
                last     <= counter;
                period   <= (state == RUN) ? counter - last : '0;
                valid    <= 1'b1;
                overrun  <= valid & ~ack;
            end else if (ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (!capture_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= ARMED;
                    ARMED:   if (accept) state <= RUN;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_capture.sv
// Self-checking bench for timer_capture: directed scenarios plus a randomised
// phase, all compared against a cycle-level reference model of the event rules.
module tb_timer_capture;

    localparam int W    = 64;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         capture_in;
    logic         capture_en;
    logic [1:0]   edge_sel;
    logic         interrupt_en;
    logic         ack;
    logic         clear_counter;
    logic [W-1:0] counter;
    logic [W-1:0] captured;
    logic [W-1:0] period;
    logic         valid;
    logic         overrun;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_cnt, m_cap, m_per, m_last;
    logic         m_valid, m_ovr, m_run, m_prev_en;
    logic [SYNC:0] m_hist;
    logic         m_lvl, m_old, m_hit;

    logic [W-1:0] wrap_base, frozen, hold_cap, pre;

    always #5 clk = ~clk;

    timer_capture #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .capture_in   (capture_in),
        .capture_en   (capture_en),
        .edge_sel     (edge_sel),
        .interrupt_en (interrupt_en),
        .ack          (ack),
        .clear_counter(clear_counter),
        .counter      (counter),
        .captured     (captured),
        .period       (period),
        .valid        (valid),
        .overrun      (overrun),
        .irq          (irq)
    );

    // Reference model: an input level sampled at one edge becomes visible SYNC
    // edges later; edges count only if capture was enabled at the previous edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = '0; m_cap = '0; m_per = '0; m_last = '0;
            m_valid = 1'b0; m_ovr = 1'b0; m_run = 1'b0; m_prev_en = 1'b0;
            m_hist = '0;
        end else begin
            m_lvl = m_hist[SYNC-1];
            m_old = m_hist[SYNC];
            case (edge_sel)
                2'b01:   m_hit = m_lvl & ~m_old;
                2'b10:   m_hit = ~m_lvl & m_old;
                2'b11:   m_hit = m_lvl ^ m_old;
                default: m_hit = 1'b0;
            endcase
            if (m_hit && capture_en && m_prev_en) begin
                m_per   = m_run ? m_cnt - m_last : '0;
                m_cap   = m_cnt;
                m_last  = m_cnt;
                m_run   = 1'b1;
                m_ovr   = m_valid & ~ack;
                m_valid = 1'b1;
            end else if (ack) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (!capture_en) m_run = 1'b0;
            m_prev_en = capture_en;
            m_hist = {m_hist[SYNC-1:0], capture_in};
            if (clear_counter) m_cnt = '0;
            else if (capture_en) m_cnt = m_cnt + 64'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        checkOutput("model_counter", counter, m_cnt);
        checkOutput("model_captured", captured, m_cap);
        checkOutput("model_period", period, m_per);
        checkFlag("model_valid", valid, m_valid);
        checkFlag("model_overrun", overrun, m_ovr);
        checkFlag("model_irq", irq, m_valid & interrupt_en);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 3) == 0) capture_in = ~capture_in;
        ack           = ($urandom_range(0, 4) == 0);
        clear_counter = ($urandom_range(0, 31) == 0);
        capture_en    = ($urandom_range(0, 19) != 0);
        interrupt_en  = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 15) == 0) edge_sel = 2'($urandom);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; capture_in = 1'b1; capture_en = 1'b0; edge_sel = 2'b01;
        interrupt_en = 1'b1; ack = 1'b0; clear_counter = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_counter", counter, 64'd0);
        checkOutput("rst_captured", captured, 64'd0);
        checkOutput("rst_period", period, 64'd0);
        checkFlag("rst_valid", valid, 1'b0);
        checkFlag("rst_overrun", overrun, 1'b0);
        checkFlag("rst_irq", irq, 1'b0);

        // Input held high through reset release and enable: must not capture.
        rst = 1'b1;
        repeat (4) tick();
        capture_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checkOutput("en_count", counter, W'(i));
            checkFlag("en_no_capture", valid, 1'b0);
        end

        $display("[TB] rising edge and period");
        capture_in = 1'b0;
        repeat (2) tick();
        capture_in = 1'b1;
        tick();
        checkFlag("lat_e0", valid, 1'b0);
        tick();
        checkFlag("lat_e1", valid, 1'b0);
        tick();
        checkFlag("lat_e2", valid, 1'b1);
        checkOutput("cap1", captured, 64'd10);
        checkOutput("cap1_period", period, 64'd0);
        checkFlag("cap1_irq", irq, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0; capture_in = 1'b0;
        checkFlag("ack1_valid", valid, 1'b0);
        for (int i = 0; i < 200 && m_cnt != 64'd108; i++) tick();
        capture_in = 1'b1;
        repeat (3) tick();
        checkFlag("cap2_valid", valid, 1'b1);
        checkOutput("cap2", captured, 64'd110);
        checkOutput("cap2_period", period, 64'd100);
        checkOutput("cap2_delta", captured - 64'd10, 64'd100);

        $display("[TB] overrun and ack priority");
        ack = 1'b1; tick(); ack = 1'b0;
        capture_in = 1'b0; repeat (2) tick();
        capture_in = 1'b1; repeat (3) tick();
        checkFlag("ovr_first", overrun, 1'b0);
        capture_in = 1'b0; tick();
        capture_in = 1'b1; repeat (3) tick();
        checkFlag("ovr_set", overrun, 1'b1);
        checkFlag("ovr_irq", irq, 1'b1);
        checkFlag("ovr_valid", valid, 1'b1);
        ack = 1'b1; tick(); ack = 1'b0;
        checkFlag("ovr_ack_valid", valid, 1'b0);
        checkFlag("ovr_ack_overrun", overrun, 1'b0);
        checkFlag("ovr_ack_irq", irq, 1'b0);
        capture_in = 1'b0; repeat (2) tick();
        capture_in = 1'b1; repeat (3) tick();
        capture_in = 1'b0; tick();
        capture_in = 1'b1; repeat (2) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        checkFlag("ackedge_valid", valid, 1'b1);
        checkFlag("ackedge_overrun", overrun, 1'b0);

        $display("[TB] counter wrap");
        ack = 1'b1; capture_in = 1'b0; edge_sel = 2'b11;
        tick(); ack = 1'b0;
        repeat (4) tick();
        wrap_base = {W{1'b1}} - 64'd3;
        force dut.counter = wrap_base;
        m_cnt = wrap_base;
        capture_in = 1'b1;
        #1 release dut.counter;
        repeat (2) tick();
        capture_in = 1'b0;
        tick();
        checkOutput("wrap_cap1", captured, {W{1'b1}} - 64'd1);
        repeat (2) tick();
        checkOutput("wrap_cap2", captured, 64'd0);
        checkOutput("wrap_period", period, 64'd2);

        $display("[TB] both edges and disable");
        ack = 1'b1; tick(); ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            capture_in = 1'b1;
            repeat (3) tick();
            if (k > 0) checkOutput("both_low_period", period, 64'd7);
            repeat (2) tick();
            capture_in = 1'b0;
            repeat (3) tick();
            checkOutput("both_high_period", period, 64'd5);
            repeat (4) tick();
        end
        capture_en = 1'b0;
        frozen = m_cnt;
        hold_cap = m_cap;
        tick();
        for (int k = 0; k < 3; k++) begin
            capture_in = 1'b1; repeat (3) tick();
            capture_in = 1'b0; repeat (3) tick();
        end
        checkOutput("dis_counter", counter, frozen);
        checkOutput("dis_captured", captured, hold_cap);
        checkOutput("dis_period", period, 64'd5);

        $display("[TB] clear with simultaneous edge");
        capture_en = 1'b1; edge_sel = 2'b01; ack = 1'b1;
        repeat (3) tick();
        ack = 1'b0;
        capture_in = 1'b1;
        repeat (2) tick();
        clear_counter = 1'b1;
        pre = m_cnt;
        tick();
        clear_counter = 1'b0;
        checkOutput("clr_captured", captured, pre);
        checkOutput("clr_counter", counter, 64'd0);
        checkOutput("clr_period", period, 64'd0);
        checkFlag("clr_valid", valid, 1'b1);

        $display("[TB] randomised phase");
        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            tick();
        end

        $display("[TB] asynchronous reset mid-run");
        capture_en = 1'b1; edge_sel = 2'b11; ack = 1'b0; clear_counter = 1'b0;
        interrupt_en = 1'b1; capture_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_counter", counter, 64'd0);
        checkOutput("arst_captured", captured, 64'd0);
        checkOutput("arst_period", period, 64'd0);
        checkFlag("arst_valid", valid, 1'b0);
        checkFlag("arst_overrun", overrun, 1'b0);
        checkFlag("arst_irq", irq, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) tick();
        capture_in = 1'b1;
        repeat (3) tick();
        checkFlag("arst_cap_valid", valid, 1'b1);
        checkOutput("arst_cap_period", period, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
